// File: rtl/issuequeue_int_pkg.sv
// Shared integer-datapath globals.
// Holds the default tag, data and opcode widths and the ALU opcode encodings
// that the integer ALU already uses. The issue queue and its bench import them.
package issuequeue_int_pkg;

  localparam int TAGW_DEF  = 6;
  localparam int DATAW_DEF = 32;
  localparam int OPW_DEF   = 6;

  typedef enum logic [OPW_DEF-1:0] {
    ALU_ADD = 6'h20,
    ALU_SUB = 6'h22,
    ALU_AND = 6'h24,
    ALU_OR  = 6'h25,
    ALU_XOR = 6'h26,
    ALU_SLT = 6'h2a
  } alu_op_e;

endpackage

// File: rtl/issuequeue_int_if.sv
// Bus bundle between the integer issue queue and its neighbours.
// It carries the dispatch write port, the CDB snoop port, flush, and the
// issue-stage handshake (issueint_ready out, issueint_equeueint_done back).
//   master : the environment (dispatch, CDB, flush, issue stage)
//   slave  : the issue queue
interface issuequeue_int_if
  import issuequeue_int_pkg::*;
#(
  parameter int TAGW  = TAGW_DEF,
  parameter int DATAW = DATAW_DEF,
  parameter int OPW   = OPW_DEF
) ();

  logic             dispatch_en;
  logic [OPW-1:0]   dispatch_opcode;
  logic [TAGW-1:0]  dispatch_rdtag;
  logic [TAGW-1:0]  dispatch_rstag;
  logic [TAGW-1:0]  dispatch_rttag;
  logic             dispatch_rsvalid;
  logic             dispatch_rtvalid;
  logic [DATAW-1:0] dispatch_rsdata;
  logic [DATAW-1:0] dispatch_rtdata;
  logic             queue_full;
  logic             cdb_valid;
  logic [TAGW-1:0]  cdb_tag;
  logic [DATAW-1:0] cdb_data;
  logic             flush;
  logic             issueint_ready;
  logic [OPW-1:0]   issueint_opcode;
  logic [DATAW-1:0] issueint_rsdata;
  logic [DATAW-1:0] issueint_rtdata;
  logic [TAGW-1:0]  issueint_rdtag;
  logic             issueint_equeueint_done;

  modport master (
    output dispatch_en, dispatch_opcode, dispatch_rdtag, dispatch_rstag, dispatch_rttag,
           dispatch_rsvalid, dispatch_rtvalid, dispatch_rsdata, dispatch_rtdata,
           cdb_valid, cdb_tag, cdb_data, flush, issueint_equeueint_done,
    input  queue_full, issueint_ready, issueint_opcode, issueint_rsdata,
           issueint_rtdata, issueint_rdtag
  );

  modport slave (
    input  dispatch_en, dispatch_opcode, dispatch_rdtag, dispatch_rstag, dispatch_rttag,
           dispatch_rsvalid, dispatch_rtvalid, dispatch_rsdata, dispatch_rtdata,
           cdb_valid, cdb_tag, cdb_data, flush, issueint_equeueint_done,
    output queue_full, issueint_ready, issueint_opcode, issueint_rsdata,
           issueint_rtdata, issueint_rdtag
  );

endinterface

// File: rtl/issuequeue_int_iq_entry.sv
// One issue-queue slot.
// Ports: clk/reset/flush; CDB snoop (cdb_valid/tag/data); shift with the
// contents of the slot above (up_*); wr with the dispatch fields (d_*);
// the registered slot fields come out as busy/opcode/rdtag/rs*/rt*.
// The next-state mux picks hold, shift-in or dispatch-write; the CDB snoop is
// then applied to whichever source was picked, so a wakeup lands on the
// post-shift position and a dispatch sees a same-cycle broadcast.
module iq_entry
  import issuequeue_int_pkg::*;
#(
  parameter int TAGW  = TAGW_DEF,
  parameter int DATAW = DATAW_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             cdb_valid,
  input  logic [TAGW-1:0]  cdb_tag,
  input  logic [DATAW-1:0] cdb_data,
  input  logic             shift,
  input  logic             up_busy,
  input  logic [OPW-1:0]   up_opcode,
  input  logic [TAGW-1:0]  up_rdtag,
  input  logic [TAGW-1:0]  up_rstag,
  input  logic             up_rsvalid,
  input  logic [DATAW-1:0] up_rsdata,
  input  logic [TAGW-1:0]  up_rttag,
  input  logic             up_rtvalid,
  input  logic [DATAW-1:0] up_rtdata,
  input  logic             wr,
  input  logic [OPW-1:0]   d_opcode,
  input  logic [TAGW-1:0]  d_rdtag,
  input  logic [TAGW-1:0]  d_rstag,
  input  logic             d_rsvalid,
  input  logic [DATAW-1:0] d_rsdata,
  input  logic [TAGW-1:0]  d_rttag,
  input  logic             d_rtvalid,
  input  logic [DATAW-1:0] d_rtdata,
  output logic             busy,
  output logic [OPW-1:0]   opcode,
  output logic [TAGW-1:0]  rdtag,
  output logic [TAGW-1:0]  rstag,
  output logic             rsvalid,
  output logic [DATAW-1:0] rsdata,
  output logic [TAGW-1:0]  rttag,
  output logic             rtvalid,
  output logic [DATAW-1:0] rtdata
);

  logic             n_busy, n_rsvalid, n_rtvalid;
  logic [OPW-1:0]   n_opcode;
  logic [TAGW-1:0]  n_rdtag, n_rstag, n_rttag;
  logic [DATAW-1:0] n_rsdata, n_rtdata;

  always_comb begin
    n_busy    = busy;
    n_opcode  = opcode;
    n_rdtag   = rdtag;
    n_rstag   = rstag;
    n_rsvalid = rsvalid;
    n_rsdata  = rsdata;
    n_rttag   = rttag;
    n_rtvalid = rtvalid;
    n_rtdata  = rtdata;
    // Dispatch wins over shift: with a same-cycle issue the write slot is the
    // one that would otherwise pull in the empty slot above it.
    if (wr) begin
      n_busy    = 1'b1;
      n_opcode  = d_opcode;
      n_rdtag   = d_rdtag;
      n_rstag   = d_rstag;
      n_rsvalid = d_rsvalid;
      n_rsdata  = d_rsdata;
      n_rttag   = d_rttag;
      n_rtvalid = d_rtvalid;
      n_rtdata  = d_rtdata;
    end else if (shift) begin
      n_busy    = up_busy;
      n_opcode  = up_opcode;
      n_rdtag   = up_rdtag;
      n_rstag   = up_rstag;
      n_rsvalid = up_rsvalid;
      n_rsdata  = up_rsdata;
      n_rttag   = up_rttag;
      n_rtvalid = up_rtvalid;
      n_rtdata  = up_rtdata;
    end
    if (cdb_valid && n_busy && !n_rsvalid && (n_rstag == cdb_tag)) begin
      n_rsvalid = 1'b1;
      n_rsdata  = cdb_data;
    end
    if (cdb_valid && n_busy && !n_rtvalid && (n_rttag == cdb_tag)) begin
      n_rtvalid = 1'b1;
      n_rtdata  = cdb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      busy    <= 1'b0;
      rsvalid <= 1'b0;
      rtvalid <= 1'b0;
    end else begin
      busy    <= n_busy;
      rsvalid <= n_rsvalid;
      rtvalid <= n_rtvalid;
    end
  end

  always_ff @(posedge clk) begin
    opcode <= n_opcode;
    rdtag  <= n_rdtag;
    rstag  <= n_rstag;
    rsdata <= n_rsdata;
    rttag  <= n_rttag;
    rtdata <= n_rtdata;
  end

endmodule

// File: rtl/issuequeue_int.sv
// Integer issue queue: DEPTH age-ordered, compacting slots (slot 0 oldest).
// Ports: clk, reset (sync, active-high), bus (slave side of issuequeue_int_if:
// dispatch write, CDB snoop, flush, issue handshake and queue_full).
// Picks the lowest-index ready slot and presents it; the outputs depend only on
// registered state, so issueint_equeueint_done can depend on issueint_ready.
module issuequeue_int
  import issuequeue_int_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = TAGW_DEF,
  parameter int DATAW = DATAW_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  issuequeue_int_if.slave   bus
);

  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int SELW = $clog2(DEPTH);

  logic             busy [DEPTH], rsvalid [DEPTH], rtvalid [DEPTH];
  logic [OPW-1:0]   opcode [DEPTH];
  logic [TAGW-1:0]  rdtag [DEPTH], rstag [DEPTH], rttag [DEPTH];
  logic [DATAW-1:0] rsdata [DEPTH], rtdata [DEPTH];

  logic             up_busy [DEPTH], up_rsvalid [DEPTH], up_rtvalid [DEPTH];
  logic [OPW-1:0]   up_opcode [DEPTH];
  logic [TAGW-1:0]  up_rdtag [DEPTH], up_rstag [DEPTH], up_rttag [DEPTH];
  logic [DATAW-1:0] up_rsdata [DEPTH], up_rtdata [DEPTH];

  logic [CNTW-1:0]  count, wr_slot;
  logic [SELW-1:0]  sel;
  logic             any_ready, issue, accept;
  logic [DEPTH-1:0] shift, wr;

  assign bus.queue_full = (count == CNTW'(DEPTH));
  assign accept  = bus.dispatch_en && !bus.queue_full;
  assign issue   = bus.issueint_equeueint_done && any_ready;
  assign wr_slot = issue ? (count - CNTW'(1)) : count;

  // Priority encoder: scanning downward leaves the lowest ready index in sel.
  always_comb begin
    sel       = '0;
    any_ready = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (busy[i] && rsvalid[i] && rtvalid[i]) begin
        sel       = SELW'(i);
        any_ready = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      shift[i] = issue && (i >= int'(sel));
      wr[i]    = accept && (int'(wr_slot) == i);
    end
  end

  always_comb begin
    bus.issueint_ready  = any_ready;
    bus.issueint_opcode = any_ready ? opcode[sel] : '0;
    bus.issueint_rdtag  = any_ready ? rdtag[sel]  : '0;
    bus.issueint_rsdata = any_ready ? rsdata[sel] : '0;
    bus.issueint_rtdata = any_ready ? rtdata[sel] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      count <= '0;
    end else begin
      count <= count + CNTW'(accept) - CNTW'(issue);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    // The top slot shifts in an empty slot.
    if (g == DEPTH - 1) begin : g_top
      assign up_busy[g]    = 1'b0;
      assign up_opcode[g]  = '0;
      assign up_rdtag[g]   = '0;
      assign up_rstag[g]   = '0;
      assign up_rsvalid[g] = 1'b0;
      assign up_rsdata[g]  = '0;
      assign up_rttag[g]   = '0;
      assign up_rtvalid[g] = 1'b0;
      assign up_rtdata[g]  = '0;
    end else begin : g_mid
      assign up_busy[g]    = busy[g+1];
      assign up_opcode[g]  = opcode[g+1];
      assign up_rdtag[g]   = rdtag[g+1];
      assign up_rstag[g]   = rstag[g+1];
      assign up_rsvalid[g] = rsvalid[g+1];
      assign up_rsdata[g]  = rsdata[g+1];
      assign up_rttag[g]   = rttag[g+1];
      assign up_rtvalid[g] = rtvalid[g+1];
      assign up_rtdata[g]  = rtdata[g+1];
    end

    iq_entry #(.TAGW(TAGW), .DATAW(DATAW), .OPW(OPW)) u_entry (
      .clk        (clk),
      .reset      (reset),
      .flush      (bus.flush),
      .cdb_valid  (bus.cdb_valid),
      .cdb_tag    (bus.cdb_tag),
      .cdb_data   (bus.cdb_data),
      .shift      (shift[g]),
      .up_busy    (up_busy[g]),
      .up_opcode  (up_opcode[g]),
      .up_rdtag   (up_rdtag[g]),
      .up_rstag   (up_rstag[g]),
      .up_rsvalid (up_rsvalid[g]),
      .up_rsdata  (up_rsdata[g]),
      .up_rttag   (up_rttag[g]),
      .up_rtvalid (up_rtvalid[g]),
      .up_rtdata  (up_rtdata[g]),
      .wr         (wr[g]),
      .d_opcode   (bus.dispatch_opcode),
      .d_rdtag    (bus.dispatch_rdtag),
      .d_rstag    (bus.dispatch_rstag),
      .d_rsvalid  (bus.dispatch_rsvalid),
      .d_rsdata   (bus.dispatch_rsdata),
      .d_rttag    (bus.dispatch_rttag),
      .d_rtvalid  (bus.dispatch_rtvalid),
      .d_rtdata   (bus.dispatch_rtdata),
      .busy       (busy[g]),
      .opcode     (opcode[g]),
      .rdtag      (rdtag[g]),
      .rstag      (rstag[g]),
      .rsvalid    (rsvalid[g]),
      .rsdata     (rsdata[g]),
      .rttag      (rttag[g]),
      .rtvalid    (rtvalid[g]),
      .rtdata     (rtdata[g])
    );
  end

endmodule

// File: tb/tb_issuequeue_int.sv
// Directed bench for issuequeue_int (DEPTH=4, TAGW=6, DATAW=32, OPW=6).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_issuequeue_int;
  import issuequeue_int_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  issuequeue_int_if bus_if ();

  issuequeue_int dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus_if.dispatch_en             = 1'b0;
    bus_if.cdb_valid               = 1'b0;
    bus_if.flush                   = 1'b0;
    bus_if.issueint_equeueint_done = 1'b0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [5:0] rd,
                      input logic [5:0] rs, input logic rsv, input logic [31:0] rsd,
                      input logic [5:0] rt, input logic rtv, input logic [31:0] rtd);
    bus_if.dispatch_en      = 1'b1;
    bus_if.dispatch_opcode  = op;
    bus_if.dispatch_rdtag   = rd;
    bus_if.dispatch_rstag   = rs;
    bus_if.dispatch_rsvalid = rsv;
    bus_if.dispatch_rsdata  = rsd;
    bus_if.dispatch_rttag   = rt;
    bus_if.dispatch_rtvalid = rtv;
    bus_if.dispatch_rtdata  = rtd;
  endtask

  task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
    bus_if.cdb_valid = 1'b1;
    bus_if.cdb_tag   = tag;
    bus_if.cdb_data  = data;
  endtask

  // done must only ever be raised while an op is presented.
  always @(negedge clk) begin
    if (bus_if.issueint_equeueint_done === 1'b1) begin
      checks++;
      assert (bus_if.issueint_ready === 1'b1)
      else begin
        errors++;
        $error("FAIL done_legal: ready=%0b required=1", bus_if.issueint_ready);
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    idle();
    disp(6'h0, 6'h0, 6'h0, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0);
    bus_if.dispatch_en = 1'b0;
    bus_if.cdb_tag  = '0;
    bus_if.cdb_data = '0;
    tick();
    tick();
    check("rst_ready",  bus_if.issueint_ready, 0);
    check("rst_full",   bus_if.queue_full, 0);
    check("rst_rdtag",  bus_if.issueint_rdtag, 0);
    check("rst_rsdata", bus_if.issueint_rsdata, 0);
    check("rst_opcode", bus_if.issueint_opcode, 0);
    check("rst_count",  dut.count, 0);
    reset = 1'b0;
    tick();

    // Simple ready op: eligible one cycle after dispatch, then issued.
    disp(ALU_ADD, 6'd5, 6'd1, 1'b1, 32'd11, 6'd2, 1'b1, 32'd22);
    #1;
    check("t1_not_same_cycle", bus_if.issueint_ready, 0);
    tick();
    idle();
    check("t1_ready",  bus_if.issueint_ready, 1);
    check("t1_rdtag",  bus_if.issueint_rdtag, 5);
    check("t1_rsdata", bus_if.issueint_rsdata, 11);
    check("t1_rtdata", bus_if.issueint_rtdata, 22);
    check("t1_opcode", bus_if.issueint_opcode, ALU_ADD);
    bus_if.issueint_equeueint_done = 1'b1;
    tick();
    idle();
    check("t1_empty_ready", bus_if.issueint_ready, 0);
    check("t1_empty_count", dut.count, 0);
    check("t1_empty_rdtag", bus_if.issueint_rdtag, 0);

    // Wakeup through a later CDB broadcast.
    disp(ALU_SUB, 6'd9, 6'd12, 1'b0, 32'h0, 6'd20, 1'b1, 32'h55);
    tick();
    idle();
    check("t2_waiting", bus_if.issueint_ready, 0);
    cdb(6'd12, 32'hDEADBEEF);
    #1;
    check("t2_no_cdb_path", bus_if.issueint_ready, 0);
    tick();
    idle();
    check("t2_ready",  bus_if.issueint_ready, 1);
    check("t2_rsdata", bus_if.issueint_rsdata, 32'hDEADBEEF);
    check("t2_rtdata", bus_if.issueint_rtdata, 32'h55);
    check("t2_rdtag",  bus_if.issueint_rdtag, 9);
    bus_if.issueint_equeueint_done = 1'b1;
    tick();
    idle();
    check("t2_count", dut.count, 0);

    // Dispatch/CDB bypass on rt.
    disp(ALU_AND, 6'd10, 6'd3, 1'b1, 32'hA, 6'd7, 1'b0, 32'h0);
    cdb(6'd7, 32'h1234);
    tick();
    idle();
    check("t3_ready",  bus_if.issueint_ready, 1);
    check("t3_rtdata", bus_if.issueint_rtdata, 32'h1234);
    check("t3_rsdata", bus_if.issueint_rsdata, 32'hA);
    bus_if.issueint_equeueint_done = 1'b1;
    tick();
    idle();
    check("t3_count", dut.count, 0);

    // Fill: slot 0 waits on tag 3, slots 1..3 ready.
    disp(ALU_OR, 6'd20, 6'd3, 1'b0, 32'h0, 6'd4, 1'b1, 32'h200);
    tick();
    disp(ALU_OR, 6'd21, 6'd1, 1'b1, 32'h211, 6'd2, 1'b1, 32'h212);
    tick();
    disp(ALU_OR, 6'd22, 6'd1, 1'b1, 32'h221, 6'd2, 1'b1, 32'h222);
    tick();
    disp(ALU_OR, 6'd23, 6'd1, 1'b1, 32'h231, 6'd2, 1'b1, 32'h232);
    tick();
    idle();
    check("t4_full",   bus_if.queue_full, 1);
    check("t4_count",  dut.count, 4);
    check("t4_rdtag",  bus_if.issueint_rdtag, 21);
    check("t4_rsdata", bus_if.issueint_rsdata, 32'h211);
    // Issue while full, with a dispatch that must be dropped.
    bus_if.issueint_equeueint_done = 1'b1;
    disp(ALU_XOR, 6'd30, 6'd1, 1'b1, 32'h301, 6'd2, 1'b1, 32'h302);
    tick();
    idle();
    check("t4_full_drop", bus_if.queue_full, 0);
    check("t4_count3",    dut.count, 3);
    check("t4_rdtag2",    bus_if.issueint_rdtag, 22);
    cdb(6'd3, 32'h33);
    tick();
    idle();
    check("t4_wake_rdtag",  bus_if.issueint_rdtag, 20);
    check("t4_wake_rsdata", bus_if.issueint_rsdata, 32'h33);
    bus_if.issueint_equeueint_done = 1'b1;
    tick();
    idle();
    check("t4_count2", dut.count, 2);
    check("t4_rdtag3", bus_if.issueint_rdtag, 22);

    // Count=2: issue + dispatch together keeps count and age order.
    bus_if.issueint_equeueint_done = 1'b1;
    disp(ALU_SLT, 6'd40, 6'd1, 1'b1, 32'h401, 6'd2, 1'b1, 32'h402);
    tick();
    idle();
    check("t5_count",  dut.count, 2);
    check("t5_rdtag",  bus_if.issueint_rdtag, 23);
    bus_if.issueint_equeueint_done = 1'b1;
    tick();
    idle();
    check("t5_count1", dut.count, 1);
    check("t5_rdtag2", bus_if.issueint_rdtag, 40);
    check("t5_rsdata", bus_if.issueint_rsdata, 32'h401);
    // Count=1: issue + dispatch lands the new op in slot 0.
    bus_if.issueint_equeueint_done = 1'b1;
    disp(ALU_ADD, 6'd41, 6'd1, 1'b1, 32'h411, 6'd2, 1'b1, 32'h412);
    tick();
    idle();
    check("t5_c1_count", dut.count, 1);
    check("t5_c1_rdtag", bus_if.issueint_rdtag, 41);
    bus_if.issueint_equeueint_done = 1'b1;
    tick();
    idle();
    check("t5_drain_ready", bus_if.issueint_ready, 0);

    // Wakeup applied at the post-shift position.
    disp(ALU_ADD, 6'd1, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2);
    tick();
    disp(ALU_ADD, 6'd2, 6'd8, 1'b0, 32'h0, 6'd2, 1'b1, 32'h22);
    tick();
    idle();
    check("t6_rdtag", bus_if.issueint_rdtag, 1);
    bus_if.issueint_equeueint_done = 1'b1;
    cdb(6'd8, 32'h88);
    tick();
    idle();
    check("t6_shift_ready",  bus_if.issueint_ready, 1);
    check("t6_shift_rdtag",  bus_if.issueint_rdtag, 2);
    check("t6_shift_rsdata", bus_if.issueint_rsdata, 32'h88);
    bus_if.issueint_equeueint_done = 1'b1;
    tick();
    idle();
    check("t6_count", dut.count, 0);

    // Flush beats dispatch and snoop.
    disp(ALU_SUB, 6'd60, 6'd50, 1'b0, 32'h0, 6'd2, 1'b1, 32'h0);
    tick();
    disp(ALU_SUB, 6'd61, 6'd50, 1'b0, 32'h0, 6'd2, 1'b1, 32'h0);
    tick();
    disp(ALU_SUB, 6'd62, 6'd50, 1'b0, 32'h0, 6'd2, 1'b1, 32'h0);
    tick();
    idle();
    check("t7_count3", dut.count, 3);
    bus_if.flush = 1'b1;
    disp(ALU_SUB, 6'd63, 6'd1, 1'b1, 32'h0, 6'd2, 1'b1, 32'h0);
    cdb(6'd50, 32'h50);
    tick();
    idle();
    check("t7_count", dut.count, 0);
    check("t7_ready", bus_if.issueint_ready, 0);
    check("t7_full",  bus_if.queue_full, 0);
    tick();
    check("t7_still_empty", bus_if.issueint_ready, 0);
    disp(ALU_ADD, 6'd35, 6'd1, 1'b1, 32'h70, 6'd2, 1'b1, 32'h71);
    tick();
    idle();
    check("t7_after_rdtag", bus_if.issueint_rdtag, 35);
    check("t7_after_count", dut.count, 1);

    // Reset mid-operation.
    disp(ALU_ADD, 6'd44, 6'd1, 1'b1, 32'h80, 6'd2, 1'b1, 32'h81);
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t8_ready", bus_if.issueint_ready, 0);
    check("t8_count", dut.count, 0);
    check("t8_full",  bus_if.queue_full, 0);
    check("t8_rdtag", bus_if.issueint_rdtag, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/issuequeue_int.md
Name: issuequeue_int

Overview:
- Integer issue queue feeding the issue/CDB stage.
- Holds up to DEPTH dispatched integer ALU ops, captures missing source operands by snooping the CDB, and presents the oldest ready op to the issue stage.
- Handshake to the issue stage: issueint_ready out, issueint_equeueint_done back.
- Dispatch sits upstream. Queue entries are age-ordered and compacting: entry 0 is always the oldest.

Parameters:
- DEPTH, 4, number of queue entries (2..8).
- TAGW, 6, physical register tag width.
- DATAW, 32, operand width.
- OPW, 6, ALU opcode width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dispatch_en  in  1  write one new op this cycle (ignored while queue_full)
- dispatch_opcode  in  OPW  ALU opcode
- dispatch_rdtag  in  TAGW  destination tag
- dispatch_rstag, dispatch_rttag  in  TAGW  source tags
- dispatch_rsvalid, dispatch_rtvalid  in  1  source data already present
- dispatch_rsdata, dispatch_rtdata  in  DATAW  source data, meaningful when the matching valid bit is 1
- queue_full  out  1  count == DEPTH (registered state)
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAGW  broadcast tag
- cdb_data  in  DATAW  broadcast data
- flush  in  1  discard all entries (branch mispredict)
- issueint_ready  out  1  a ready op is presented
- issueint_opcode  out  OPW  opcode of the selected op
- issueint_rsdata  out  DATAW  rs data of the selected op
- issueint_rtdata  out  DATAW  rt data of the selected op
- issueint_rdtag  out  TAGW  rd tag of the selected op
- issueint_equeueint_done  in  1  issue stage accepted the presented op this cycle

Behaviour:
- Per-entry state: busy, opcode, rdtag, rstag, rsvalid, rsdata, rttag, rtvalid, rtdata. count is 0..DEPTH.
- Reset, synchronous: all busy, rsvalid and rtvalid bits = 0; count = 0; queue_full = 0; issueint_ready = 0; all data outputs = 0.
- Select logic:
  - An entry is ready when busy & rsvalid & rtvalid.
  - sel = lowest-index ready entry.
  - Outputs are combinational from registered state only, with no path from issueint_equeueint_done or cdb_* to the outputs. This prevents a loop with the issue stage, whose done depends on ready.
  - With no ready entry, issueint_ready = 0 and the data outputs are 0.
  - An op becomes eligible at the earliest one cycle after it is written or woken up.
- Issue: when issueint_equeueint_done = 1, entry sel is removed. Entries above sel shift down one slot and count decrements. done while issueint_ready = 0 is an illegal input; the bench asserts it never occurs.
- CDB snoop: for each busy entry with rsvalid = 0 and rstag == cdb_tag while cdb_valid = 1, set rsvalid = 1 and rsdata = cdb_data. rt is handled identically.
- Snoop and shift in the same cycle: the wakeup is applied to the entry at its post-shift position.
- Dispatch write:
  - Accepted when dispatch_en & ~queue_full.
  - Written at slot count, or at count-1 if an issue happens in the same cycle.
  - Dispatch/CDB bypass: if a dispatching source is invalid and its tag matches a valid CDB broadcast in the same cycle, the entry is written with valid = 1 and the CDB data.
- Full boundary: queue_full is based on registered count. Dispatch while full is dropped, even if an issue frees a slot the same cycle. Upstream must hold the op.
- Simultaneous dispatch + issue with count = 1: the new op lands in slot 0 and count stays 1.
- Flush: next cycle all busy bits = 0 and count = 0. Flush has priority over dispatch, issue and snoop in that cycle.
- Reset mid-operation: same result as flush; all pending wakeups are lost.

Decomposition:
- Shared globals: TAGW/DATAW/OPW defaults and the ALU opcode constants, already used by the integer ALU.
- Sub-module iq_entry: one slot with its registers, CDB tag compare and a next-state mux selecting hold / shift-in-from-above / dispatch-write.
- Top level holds the priority encoder for sel, count and the shift enables.

Test Plan:
- Dispatch op (rs valid, rt valid, rdtag=5), no CDB -> issueint_ready=1 next cycle with rdtag=5; done asserted -> queue empty, ready=0 the following cycle.
- Dispatch op with rstag=12 invalid, then cdb_valid=1 with tag=12 and data=0xDEADBEEF -> ready=1 the cycle after the broadcast, issueint_rsdata=0xDEADBEEF.
- Dispatch with rttag=7 invalid in the same cycle as a CDB broadcast of tag 7, data 0x1234 -> entry written valid; ready=1 next cycle with rtdata=0x1234.
- Fill 4 entries where entry0 waits on tag 3 and entries 1..3 are ready; issue one -> rdtag of entry1 presented; queue_full drops and a dispatch attempted during the full cycle is dropped (count stays 3).
- Count=2 with the older op ready; done and dispatch in the same cycle -> count stays 2, age order preserved (old entry1 is now slot 0).
- 3 entries valid; flush asserted together with dispatch_en and a matching CDB broadcast -> next cycle count=0, ready=0, queue_full=0.
